// File: rtl/sv_bus_pkg.sv
// Shared types for the 64-bit request-bus responder.
// Response bundle and FSM state encoding.
package sv_bus_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 3;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [TAG_W-1:0]  rtag;
        logic              rerr;
    } rsp_t;

endpackage

// File: rtl/sv_bus_responder_if.sv
// Request/response bus between one initiator and the responder.
// master = initiator side, slave = responder side.
interface sv_bus_responder_if
    import sv_bus_pkg::*;
#(
    parameter int ID_W = TAG_W
) ();

    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   valid;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              ren;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rtag;
    logic              rerr;
    logic              rvalid;
    logic              rready;

    modport master (
        output addr, valid, data, wen, ren, rready,
        input  ready, rdata, rtag, rerr, rvalid
    );

    modport slave (
        input  addr, valid, data, wen, ren, rready,
        output ready, rdata, rtag, rerr, rvalid
    );

endinterface

// File: rtl/sv_bus_rsp_fifo.sv
// Show-ahead response FIFO; head entry is visible on dout.
// A push is accepted when full only if a pop happens on the same edge.
module sv_bus_rsp_fifo
    import sv_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  rsp_t                   din,
    input  logic                   pop,
    output rsp_t                   dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rsp_t          mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign dout    = mem[rptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + PW'(1);
            end
            if (do_pop) rptr <= rptr + PW'(1);
            if (do_push && !do_pop) count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // credit accounting upstream must make a dropped push impossible
    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset) !(push && !do_push)
    );

endmodule

// File: rtl/sv_bus_responder.sv
// Bus target: posted writes into local memory, tagged reads via a FIFO.
// Memory is zeroed one word per cycle after every reset.
module sv_bus_responder
    import sv_bus_pkg::*;
#(
    parameter int                MEM_DEPTH = 256,
    parameter int                ID_W      = TAG_W,
    parameter int                RSP_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    sv_bus_responder_if.slave bus
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    state_t            state;
    logic [AW-1:0]     clr_idx;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              s1_v;
    logic              s1_err;
    logic [ID_W-1:0]   s1_tag;
    logic [AW-1:0]     s1_idx;
    logic              s2_v;
    rsp_t              s2_rsp;
    logic [15:0]       err_cnt;

    rsp_t              head;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic              pop;

    logic              hit;
    logic              acc;
    logic              wr_fire;
    logic              wr_bad;
    logic              rd_fire;
    logic [AW-1:0]     idx;
    logic [CW-1:0]     used;
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [DATA_W-1:0] mem_wd;

    assign hit = (bus.addr[ADDR_W-1:AW+3] == BASE_ADDR[ADDR_W-1:AW+3])
               && (bus.addr[2:0] == 3'b000);
    assign idx = bus.addr[AW+2:3];

    // every read in flight already owns a FIFO slot
    assign used      = fifo_cnt + CW'(s1_v) + CW'(s2_v);
    assign bus.ready = (state == RUN) && (used < CW'(RSP_DEPTH));

    assign acc     = (bus.wen | bus.ren) & bus.ready;
    assign wr_fire = acc & bus.wen & ~bus.ren & hit;
    assign wr_bad  = acc & bus.wen & ~bus.ren & ~hit;
    assign rd_fire = acc & bus.ren;

    assign mem_we = (state == INIT) | wr_fire;
    assign mem_wa = (state == INIT) ? clr_idx : idx;
    assign mem_wd = (state == INIT) ? '0 : bus.data;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            clr_idx <= '0;
            s1_v    <= 1'b0;
            s1_err  <= 1'b0;
            s1_tag  <= '0;
            s1_idx  <= '0;
            s2_v    <= 1'b0;
            s2_rsp  <= '0;
            err_cnt <= '0;
        end else begin
            if (state == INIT) begin
                clr_idx <= clr_idx + AW'(1);
                if (&clr_idx) state <= RUN;
            end
            // wen+ren together is answered as an error read
            s1_v         <= rd_fire;
            s1_err       <= ~hit | bus.wen;
            s1_tag       <= bus.valid;
            s1_idx       <= idx;
            s2_v         <= s1_v;
            s2_rsp.rdata <= s1_err ? '0 : mem[s1_idx];
            s2_rsp.rtag  <= TAG_W'(s1_tag);
            s2_rsp.rerr  <= s1_err;
            if (wr_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    a_err_mono: assert property (
        @(posedge clk) disable iff (reset) err_cnt >= $past(err_cnt)
    );

    assign pop = bus.rvalid & bus.rready;

    sv_bus_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s2_v),
        .din   (s2_rsp),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.rvalid = ~fifo_empty;
    assign bus.rdata  = head.rdata;
    assign bus.rtag   = ID_W'(head.rtag);
    assign bus.rerr   = head.rerr;

endmodule

// File: tb/tb_sv_bus_responder.sv
// Directed bench for sv_bus_responder: init, RAW, credits, errors, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sv_bus_responder;
    import sv_bus_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    sv_bus_responder_if #(.ID_W(3)) bus ();

    sv_bus_responder #(
        .MEM_DEPTH (256),
        .ID_W      (3),
        .RSP_DEPTH (4),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a falling edge; returns at the falling edge after acceptance
    task automatic req(input logic w, input logic r, input logic [31:0] a,
                       input logic [2:0] t, input logic [63:0] d);
        int n = 0;
        bus.addr  = a;
        bus.valid = t;
        bus.data  = d;
        bus.wen   = w;
        bus.ren   = r;
        while (!bus.ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", (n < 600), 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.wen = 1'b0;
        bus.ren = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] d,
                           input logic [2:0] t, input logic e);
        int n = 0;
        while (!bus.rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rvalid"}, bus.rvalid, 1'b1);
        chk({tag, "_rdata"}, bus.rdata, d);
        chk({tag, "_rtag"}, bus.rtag, t);
        chk({tag, "_rerr"}, bus.rerr, e);
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!bus.ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, 256);
    endtask

    initial begin
        logic [31:0] ra [4];
        logic [63:0] rd [4];
        ra = '{32'h8, 32'h10, 32'h18, 32'h20};
        rd = '{64'hDEAD_BEEF_0123_4567, 64'h1111, 64'h2222, 64'h0};

        reset      = 1'b1;
        bus.addr   = '0;
        bus.valid  = '0;
        bus.data   = '0;
        bus.wen    = 1'b0;
        bus.ren    = 1'b0;
        bus.rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rdata", bus.rdata, 64'h0);
        chk("rst_rtag", bus.rtag, 3'd0);
        chk("rst_rerr", bus.rerr, 1'b0);

        reset = 1'b0;
        wait_init("init_cycles");

        req(1'b0, 1'b1, 32'h10, 3'd1, 64'h0);
        pop_chk("rd_cold", 64'h0, 3'd1, 1'b0);

        // write at edge k, read at k+1, response visible after k+3
        req(1'b1, 1'b0, 32'h8, 3'd0, 64'hDEAD_BEEF_0123_4567);
        req(1'b0, 1'b1, 32'h8, 3'd5, 64'h0);
        chk("raw_k1", bus.rvalid, 1'b0);
        @(negedge clk);
        chk("raw_k2", bus.rvalid, 1'b0);
        @(negedge clk);
        chk("raw_k3", bus.rvalid, 1'b1);
        pop_chk("raw", 64'hDEAD_BEEF_0123_4567, 3'd5, 1'b0);
        chk("raw_popped", bus.rvalid, 1'b0);

        req(1'b1, 1'b0, 32'h10, 3'd0, 64'h1111);
        req(1'b1, 1'b0, 32'h18, 3'd0, 64'h2222);
        for (int i = 0; i < 4; i++) req(1'b0, 1'b1, ra[i], 3'(i), 64'h0);
        chk("credit_full", bus.ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("credit_hold", bus.ready, 1'b0);
        chk("credit_rvalid", bus.rvalid, 1'b1);
        pop_chk("bb0", rd[0], 3'd0, 1'b0);
        chk("ready_after_pop", bus.ready, 1'b1);
        for (int i = 1; i < 4; i++)
            pop_chk($sformatf("bb%0d", i), rd[i], 3'(i), 1'b0);

        req(1'b0, 1'b1, 32'h800, 3'd6, 64'h0);
        pop_chk("rd_miss", 64'h0, 3'd6, 1'b1);
        req(1'b0, 1'b1, 32'h4, 3'd7, 64'h0);
        pop_chk("rd_misalign", 64'h0, 3'd7, 1'b1);
        req(1'b1, 1'b0, 32'h800, 3'd0, 64'hBAD0_BAD0);
        repeat (4) @(negedge clk);
        chk("wmiss_norsp", bus.rvalid, 1'b0);
        chk("wmiss_errcnt", dut.err_cnt, 16'd1);
        req(1'b0, 1'b1, 32'h0, 3'd3, 64'h0);
        pop_chk("wmiss_mem", 64'h0, 3'd3, 1'b0);

        req(1'b1, 1'b1, 32'h8, 3'd2, 64'hFFFF_FFFF);
        pop_chk("both", 64'h0, 3'd2, 1'b1);
        req(1'b0, 1'b1, 32'h8, 3'd4, 64'h0);
        pop_chk("both_mem", 64'hDEAD_BEEF_0123_4567, 3'd4, 1'b0);

        for (int i = 0; i < 3; i++) req(1'b0, 1'b1, ra[i], 3'(i), 64'h0);
        repeat (3) @(negedge clk);
        chk("pre_rst_rvalid", bus.rvalid, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst_rvalid", bus.rvalid, 1'b0);
        chk("async_rst_ready", bus.ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_errcnt", dut.err_cnt, 16'd0);
        wait_init("reinit_cycles");
        chk("reinit_empty", bus.rvalid, 1'b0);
        req(1'b0, 1'b1, 32'h8, 3'd1, 64'h0);
        pop_chk("reinit_w8", 64'h0, 3'd1, 1'b0);
        req(1'b0, 1'b1, 32'h10, 3'd2, 64'h0);
        pop_chk("reinit_w10", 64'h0, 3'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
